// File: rtl/bp_be_pkg.sv
// Shared back-end definitions for the FE command scheduler.
package bp_be_pkg;

    // Scheduler FSM: issue freely, or hold everything while a fence drains in the FE
    typedef enum logic [1:0] {
        e_ready        = 2'd0,
        e_fence_issued = 2'd1,
        e_fence_wait   = 2'd2
    } bp_be_fe_cmd_sched_state_e;

    // Pointer width for a circular buffer of n entries (at least one bit)
    function automatic int unsigned fifo_ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_be_fe_cmd_fifo.sv
// Tagged circular FIFO holding FE commands; a flush may keep one same-cycle write.
module bp_be_fe_cmd_fifo
    import bp_be_pkg::*;
#(
    parameter int unsigned width_p = 109,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] enq_data_i,
    input  logic               enq_tag_i,
    input  logic               deq_i,
    input  logic               flush_i,
    output logic [width_p-1:0] head_data_o,
    output logic               head_tag_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned ptr_w = fifo_ptr_width(els_p);
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] data_mem [els_p];
    logic [els_p-1:0]   tag_mem;
    logic [ptr_w-1:0]   rd_ptr, wr_ptr, wr_addr;
    logic [cnt_w-1:0]   count;

    // Advance a pointer with wrap at els_p
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    // A write that survives a flush becomes the only entry, in slot 0
    assign wr_addr = flush_i ? '0 : wr_ptr;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= enq_i ? ptr_w'(1) : '0;
            count  <= enq_i ? cnt_w'(1) : '0;
        end else begin
            if (enq_i) wr_ptr <= ptr_inc(wr_ptr);
            if (deq_i) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({enq_i, deq_i})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are meaningless until written so it carries no reset
    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            data_mem[wr_addr] <= enq_data_i;
            tag_mem[wr_addr]  <= enq_tag_i;
        end
    end

    assign head_data_o = data_mem[rd_ptr];
    assign head_tag_o  = tag_mem[rd_ptr];
    assign empty_o     = (count == '0);
    assign full_o      = (count == cnt_w'(els_p));

endmodule

// File: rtl/bp_be_fe_cmd_sched.sv
// Arbitrates redirect/fence/fill requests into a command FIFO toward the FE and
// stalls issue while an icache fence is outstanding.
module bp_be_fe_cmd_sched
    import bp_be_pkg::*;
#(
    parameter int unsigned fe_cmd_width_p = 109,
    parameter int unsigned els_p          = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      redirect_v_i,
    input  logic [fe_cmd_width_p-1:0] redirect_cmd_i,
    output logic                      redirect_ready_o,
    input  logic                      fence_v_i,
    input  logic [fe_cmd_width_p-1:0] fence_cmd_i,
    output logic                      fence_ready_o,
    input  logic                      fill_v_i,
    input  logic [fe_cmd_width_p-1:0] fill_cmd_i,
    output logic                      fill_ready_o,
    output logic [fe_cmd_width_p-1:0] fe_cmd_o,
    output logic                      fe_cmd_v_o,
    input  logic                      fe_cmd_ready_i,
    input  logic                      fe_cmd_fence_i,
    input  logic                      flush_i,
    output logic                      busy_o
);

    bp_be_fe_cmd_sched_state_e state_r, state_n;

    logic                      can_accept, accept, fifo_enq, deq;
    logic [fe_cmd_width_p-1:0] enq_cmd, head_data;
    logic                      head_tag, empty, full;

    // Fixed-priority arbitration; a slot freed by a same-cycle dequeue is not reused
    assign can_accept       = ~reset_i & (state_r == e_ready) & ~full;
    assign redirect_ready_o = can_accept & redirect_v_i;
    assign fence_ready_o    = can_accept & ~redirect_v_i & fence_v_i;
    assign fill_ready_o     = can_accept & ~redirect_v_i & ~fence_v_i & fill_v_i;
    assign accept           = redirect_ready_o | fence_ready_o | fill_ready_o;

    assign enq_cmd  = redirect_ready_o ? redirect_cmd_i
                    : fence_ready_o    ? fence_cmd_i
                    :                    fill_cmd_i;
    // A flush only lets a same-cycle redirect through
    assign fifo_enq = accept & (~flush_i | redirect_ready_o);

    bp_be_fe_cmd_fifo #(
        .width_p (fe_cmd_width_p),
        .els_p   (els_p)
    ) fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enq_i       (fifo_enq),
        .enq_data_i  (enq_cmd),
        .enq_tag_i   (fence_ready_o),
        .deq_i       (deq),
        .flush_i     (flush_i),
        .head_data_o (head_data),
        .head_tag_o  (head_tag),
        .empty_o     (empty),
        .full_o      (full)
    );

    assign fe_cmd_v_o = ~reset_i & (state_r == e_ready) & ~empty;
    assign fe_cmd_o   = fe_cmd_v_o ? head_data : '0;
    assign deq        = fe_cmd_v_o & fe_cmd_ready_i;
    assign busy_o     = ~reset_i & (~empty | (state_r != e_ready));

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_ready;
        else         state_r <= state_n;
    end

    // Next state: a dequeued fence blocks issue until the FE drops its fence flag
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready:        if (deq && head_tag) state_n = e_fence_issued;
            e_fence_issued: state_n = e_fence_wait;
            e_fence_wait:   if (!fe_cmd_fence_i) state_n = e_ready;
            default:        state_n = e_ready;
        endcase
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_sched.sv
// Directed bench for the FE command scheduler: a cycle table plus hand sequences.
module tb_bp_be_fe_cmd_sched;

    localparam int unsigned W = 109;

    logic         clk = 1'b0;
    logic         reset;
    logic         redirect_v, fence_v, fill_v;
    logic [W-1:0] redirect_cmd, fence_cmd, fill_cmd;
    logic         fe_ready, fe_fence, flush;

    logic         rr2, fr2, lr2, v2, busy2;
    logic [W-1:0] cmd2;
    logic         rr3, fr3, lr3, v3, busy3;
    logic [W-1:0] cmd3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_be_fe_cmd_sched #(.fe_cmd_width_p(W), .els_p(2)) dut2 (
        .clk_i(clk), .reset_i(reset),
        .redirect_v_i(redirect_v), .redirect_cmd_i(redirect_cmd), .redirect_ready_o(rr2),
        .fence_v_i(fence_v), .fence_cmd_i(fence_cmd), .fence_ready_o(fr2),
        .fill_v_i(fill_v), .fill_cmd_i(fill_cmd), .fill_ready_o(lr2),
        .fe_cmd_o(cmd2), .fe_cmd_v_o(v2), .fe_cmd_ready_i(fe_ready),
        .fe_cmd_fence_i(fe_fence), .flush_i(flush), .busy_o(busy2)
    );

    // Deeper instance so a redirect can be accepted while two fills are buffered
    bp_be_fe_cmd_sched #(.fe_cmd_width_p(W), .els_p(3)) dut3 (
        .clk_i(clk), .reset_i(reset),
        .redirect_v_i(redirect_v), .redirect_cmd_i(redirect_cmd), .redirect_ready_o(rr3),
        .fence_v_i(fence_v), .fence_cmd_i(fence_cmd), .fence_ready_o(fr3),
        .fill_v_i(fill_v), .fill_cmd_i(fill_cmd), .fill_ready_o(lr3),
        .fe_cmd_o(cmd3), .fe_cmd_v_o(v3), .fe_cmd_ready_i(fe_ready),
        .fe_cmd_fence_i(fe_fence), .flush_i(flush), .busy_o(busy3)
    );

    typedef struct {
        logic        rv, fv, lv;
        logic [31:0] rc, fc, lc;
        logic        rdy, fen, fl;
        logic        er, ef, el, ev;
        logic [31:0] ecmd;
        logic        ebusy;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic rv, fv, lv, input logic [31:0] rc, fc, lc,
                                input logic rdy, fen, fl, input logic er, ef, el, ev,
                                input logic [31:0] ecmd, input logic ebusy);
        vec_t v;
        v.rv = rv; v.fv = fv; v.lv = lv; v.rc = rc; v.fc = fc; v.lc = lc;
        v.rdy = rdy; v.fen = fen; v.fl = fl;
        v.er = er; v.ef = ef; v.el = el; v.ev = ev; v.ecmd = ecmd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        redirect_v = 1'b0; fence_v = 1'b0; fill_v = 1'b0;
        redirect_cmd = '0; fence_cmd = '0; fill_cmd = '0;
        fe_ready = 1'b0; fe_fence = 1'b0; flush = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        redirect_v = 1'b1; fence_v = 1'b1; fill_v = 1'b1;
        // 0x100/0x200/0x300 redirect/fence/fill, then fence stall, full buffer, flushes
        tbl[0]  = mk(1,1,1, 32'h100,32'h200,32'h300, 1,0,0, 1,0,0,0, 32'h0,   0);
        tbl[1]  = mk(0,1,1, 32'h0,  32'h200,32'h300, 1,0,0, 0,1,0,1, 32'h100, 1);
        tbl[2]  = mk(0,0,1, 32'h0,  32'h0,  32'h300, 1,0,0, 0,0,1,1, 32'h200, 1);
        tbl[3]  = mk(0,0,1, 32'h0,  32'h0,  32'h301, 1,1,0, 0,0,0,0, 32'h0,   1);
        tbl[4]  = mk(0,0,1, 32'h0,  32'h0,  32'h301, 1,1,0, 0,0,0,0, 32'h0,   1);
        tbl[5]  = mk(0,0,1, 32'h0,  32'h0,  32'h301, 1,1,0, 0,0,0,0, 32'h0,   1);
        tbl[6]  = mk(0,0,1, 32'h0,  32'h0,  32'h301, 1,0,0, 0,0,0,0, 32'h0,   1);
        tbl[7]  = mk(0,0,1, 32'h0,  32'h0,  32'h301, 0,0,0, 0,0,1,1, 32'h300, 1);
        tbl[8]  = mk(0,0,1, 32'h0,  32'h0,  32'h302, 0,0,0, 0,0,0,1, 32'h300, 1);
        tbl[9]  = mk(0,0,1, 32'h0,  32'h0,  32'h303, 0,0,1, 0,0,0,1, 32'h300, 1);
        tbl[10] = mk(0,0,0, 32'h0,  32'h0,  32'h0,   0,0,0, 0,0,0,0, 32'h0,   0);
        tbl[11] = mk(0,0,1, 32'h0,  32'h0,  32'h304, 0,0,1, 0,0,1,0, 32'h0,   0);
        tbl[12] = mk(0,0,0, 32'h0,  32'h0,  32'h0,   0,0,0, 0,0,0,0, 32'h0,   0);
        tbl[13] = mk(1,0,0, 32'h500,32'h0,  32'h0,   0,0,1, 1,0,0,0, 32'h0,   0);
        tbl[14] = mk(0,0,0, 32'h0,  32'h0,  32'h0,   1,0,0, 0,0,0,1, 32'h500, 1);
        tbl[15] = mk(0,0,0, 32'h0,  32'h0,  32'h0,   0,0,0, 0,0,0,0, 32'h0,   0);

        // Reset state, with every request valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.redirect_ready", W'(rr2), W'(0));
        check("rst.fence_ready",    W'(fr2), W'(0));
        check("rst.fill_ready",     W'(lr2), W'(0));
        check("rst.fe_cmd_v",       W'(v2),  W'(0));
        check("rst.busy",           W'(busy2), W'(0));
        check("rst.fe_cmd",         cmd2,    W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        // Table of single-cycle vectors
        for (int i = 0; i < 16; i++) begin
            redirect_v = tbl[i].rv; fence_v = tbl[i].fv; fill_v = tbl[i].lv;
            redirect_cmd = W'(tbl[i].rc); fence_cmd = W'(tbl[i].fc); fill_cmd = W'(tbl[i].lc);
            fe_ready = tbl[i].rdy; fe_fence = tbl[i].fen; flush = tbl[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d.redirect_ready", i), W'(rr2), W'(tbl[i].er));
            check($sformatf("vec%0d.fence_ready", i),    W'(fr2), W'(tbl[i].ef));
            check($sformatf("vec%0d.fill_ready", i),     W'(lr2), W'(tbl[i].el));
            check($sformatf("vec%0d.fe_cmd_v", i),       W'(v2),  W'(tbl[i].ev));
            check($sformatf("vec%0d.busy", i),           W'(busy2), W'(tbl[i].ebusy));
            if (tbl[i].ev) check($sformatf("vec%0d.fe_cmd", i), cmd2, W'(tbl[i].ecmd));
            next_cycle();
        end
        idle();

        // Fence handshake in cycle 5, FE fence flag high cycles 6-9; the wait ends on the
        // edge that samples the flag low (end of cycle 10), so the fill issues in cycle 11
        for (int c = 0; c <= 12; c++) begin
            idle();
            if (c == 0) begin fence_v = 1'b1; fence_cmd = W'(32'h210); end
            if (c == 1) begin fill_v = 1'b1; fill_cmd = W'(32'h310); end
            fe_ready = (c >= 5);
            fe_fence = (c >= 6 && c <= 9);
            @(negedge clk);
            if (c == 0) check("fence.c0.fence_ready", W'(fr2), W'(1));
            if (c == 1) check("fence.c1.fill_ready", W'(lr2), W'(1));
            if (c >= 1 && c <= 5) begin
                check($sformatf("fence.c%0d.v", c), W'(v2), W'(1));
                check($sformatf("fence.c%0d.cmd", c), cmd2, W'(32'h210));
            end
            if (c >= 6 && c <= 10) begin
                check($sformatf("fence.c%0d.v", c), W'(v2), W'(0));
                check($sformatf("fence.c%0d.busy", c), W'(busy2), W'(1));
            end
            if (c == 11) begin
                check("fence.c11.v", W'(v2), W'(1));
                check("fence.c11.cmd", cmd2, W'(32'h310));
            end
            if (c == 12) check("fence.c12.busy", W'(busy2), W'(0));
            next_cycle();
        end
        idle();

        // Reset asserted between edges while waiting on a fence
        fence_v = 1'b1; fence_cmd = W'(32'h220);
        next_cycle();
        idle(); fe_ready = 1'b1;
        next_cycle();
        idle(); fe_fence = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rstmid.pre.v", W'(v2), W'(0));
        check("rstmid.pre.busy", W'(busy2), W'(1));
        #2;
        reset = 1'b1;
        fill_v = 1'b1; fill_cmd = W'(32'h320);
        #1;
        check("rstmid.v", W'(v2), W'(0));
        check("rstmid.busy", W'(busy2), W'(0));
        check("rstmid.fill_ready", W'(lr2), W'(0));
        check("rstmid.fe_cmd", cmd2, W'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid.release.fill_ready", W'(lr2), W'(1));
        next_cycle();
        idle(); fe_ready = 1'b1;
        @(negedge clk);
        check("rstmid.after.v", W'(v2), W'(1));
        check("rstmid.after.cmd", cmd2, W'(32'h320));
        next_cycle();
        idle();
        @(negedge clk);
        check("rstmid.after.busy", W'(busy2), W'(0));
        next_cycle();

        // Eight back-to-back fills through a 2-deep buffer keep their order across wraps
        for (int c = 0; c <= 8; c++) begin
            idle();
            fe_ready = 1'b1;
            if (c < 8) begin fill_v = 1'b1; fill_cmd = W'(c); end
            @(negedge clk);
            if (c < 8) check($sformatf("wrap.c%0d.fill_ready", c), W'(lr2), W'(1));
            if (c == 0) check("wrap.c0.v", W'(v2), W'(0));
            else begin
                check($sformatf("wrap.c%0d.v", c), W'(v2), W'(1));
                check($sformatf("wrap.c%0d.cmd", c), cmd2, W'(c - 1));
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("wrap.end.busy", W'(busy2), W'(0));
        next_cycle();

        // Flush with a same-cycle redirect on the 3-deep instance holding two fills
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            idle();
            if (c == 0) begin fill_v = 1'b1; fill_cmd = W'(32'h11); end
            if (c == 1) begin fill_v = 1'b1; fill_cmd = W'(32'h12); end
            if (c == 2) begin redirect_v = 1'b1; redirect_cmd = W'(32'h80000000); flush = 1'b1; end
            fe_ready = (c == 3);
            @(negedge clk);
            if (c <= 1) check($sformatf("flush.c%0d.fill_ready", c), W'(lr3), W'(1));
            if (c == 2) begin
                check("flush.c2.redirect_ready", W'(rr3), W'(1));
                check("flush.c2.cmd", cmd3, W'(32'h11));
            end
            if (c == 3) begin
                check("flush.c3.v", W'(v3), W'(1));
                check("flush.c3.cmd", cmd3, W'(32'h80000000));
            end
            if (c == 4) begin
                check("flush.c4.v", W'(v3), W'(0));
                check("flush.c4.busy", W'(busy3), W'(0));
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
